// File: rtl/serial_link_pkg.sv
// ============================================================================
// Module   : serial_link_pkg
// Purpose  : Shared types and constants for the serial parity link.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } rx_state_t;

  // Parity polarity shared with the serializer: 0 selects even parity.
  localparam logic EVEN = 1'b0;

endpackage : serial_link_pkg

`default_nettype wire

// File: rtl/serial_parity_deserializer_out_hold_reg.sv
// ============================================================================
// Module   : out_hold_reg
// Purpose  : WIDTH+1-bit valid/ready holding register for received words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_err,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_parity_err,
  output logic             m_valid,
  output logic             free
);

  // Free when empty, or when the held word is being accepted this cycle.
  assign free = !m_valid || m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data       <= '0;
      m_parity_err <= 1'b0;
      m_valid      <= 1'b0;
    end else if (load && free) begin
      m_data       <= load_data;
      m_parity_err <= load_err;
      m_valid      <= 1'b1;
    end else if (m_valid && m_ready) begin
      m_valid      <= 1'b0;
    end
  end

endmodule : out_hold_reg

`default_nettype wire

// File: rtl/serial_parity_deserializer.sv
// ============================================================================
// Module   : serial_parity_deserializer
// Purpose  : LSB-first serial receiver with even-parity check and resync.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_parity_deserializer
  import serial_link_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_bit,
  input  logic             s_valid,
  input  logic             s_start,
  output logic [WIDTH-1:0] m_data,
  output logic             m_parity_err,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             overrun,
  output logic             sync_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_nxt;
  logic             acc;
  logic             acc_nxt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             load_req;
  logic             par_err_nxt;
  logic             sync_nxt;
  logic             free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      acc      <= 1'b0;
      count    <= '0;
      overrun  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      acc      <= acc_nxt;
      count    <= count_nxt;
      overrun  <= load_req && !free;
      sync_err <= sync_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    acc_nxt     = acc;
    count_nxt   = count;
    load_req    = 1'b0;
    par_err_nxt = 1'b0;
    sync_nxt    = 1'b0;

    if (s_valid) begin
      if (s_start) begin
        // A start beat always opens a new frame; mid-frame it aborts the old one.
        shift_nxt    = '0;
        shift_nxt[0] = s_bit;
        acc_nxt      = s_bit;
        count_nxt    = CW'(1);
        state_nxt    = DATA;
        sync_nxt     = (state != IDLE);
      end else begin
        case (state)
          IDLE: begin
          end
          DATA: begin
            for (int i = 0; i < WIDTH; i++) begin
              if (count == CW'(i)) begin
                shift_nxt[i] = s_bit;
              end
            end
            acc_nxt   = acc ^ s_bit;
            count_nxt = count + CW'(1);
            if (count == CW'(WIDTH - 1)) begin
              state_nxt = PARITY;
            end
          end
          PARITY: begin
            load_req    = 1'b1;
            par_err_nxt = s_bit ^ acc ^ EVEN;
            count_nxt   = '0;
            state_nxt   = IDLE;
          end
          default: begin
            state_nxt = IDLE;
            count_nxt = '0;
          end
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

  out_hold_reg #(
    .WIDTH (WIDTH)
  ) u_out_hold_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load_req),
    .load_data    (shift),
    .load_err     (par_err_nxt),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_parity_err (m_parity_err),
    .m_valid      (m_valid),
    .free         (free)
  );

endmodule : serial_parity_deserializer

`default_nettype wire

// File: tb/tb_serial_parity_deserializer.sv
// ============================================================================
// Module   : tb_serial_parity_deserializer
// Purpose  : Directed self-checking bench for serial_parity_deserializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_parity_deserializer;

  logic       clk;
  logic       rst_n;
  logic       s_bit;
  logic       s_valid;
  logic       s_start;
  logic [7:0] m_data;
  logic       m_parity_err;
  logic       m_valid;
  logic       m_ready;
  logic       overrun;
  logic       sync_err;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  serial_parity_deserializer #(
    .WIDTH (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_bit        (s_bit),
    .s_valid      (s_valid),
    .s_start      (s_start),
    .m_data       (m_data),
    .m_parity_err (m_parity_err),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .overrun      (overrun),
    .sync_err     (sync_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic beat(input logic b, input logic st);
    @(negedge clk);
    s_valid = 1'b1;
    s_bit   = b;
    s_start = st;
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
    s_bit   = 1'b0;
    s_start = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      beat(d[i], i == 0);
      if (gaps) idle();
    end
    beat(p, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_bit = 1'b0; s_start = 1'b0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({m_valid, m_data, m_parity_err, overrun, sync_err, busy} !== 13'h0) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b data=%h err=%b ovr=%b sync=%b busy=%b, want all 0",
               m_valid, m_data, m_parity_err, overrun, sync_err, busy);
    end
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_good_frame();
    m_ready = 1'b1;
    beat(1'b1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL good_busy: got %b want 1", busy);
    end
    for (int i = 1; i < 8; i++) begin
      s_bit = (8'hA5 >> i) & 1; s_start = 1'b0;
      if (i < 7) @(negedge clk);
    end
    beat(1'b0, 1'b0);
    idle();
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || m_parity_err !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL good_word: got valid=%b data=%h err=%b busy=%b, want 1 a5 0 0",
               m_valid, m_data, m_parity_err, busy);
    end
    idle();
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++; $display("FAIL good_one_cycle: got valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_bad_parity();
    m_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle();
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || m_parity_err !== 1'b1) begin
      n_err++;
      $display("FAIL bad_parity: got valid=%b data=%h err=%b, want 1 a5 1",
               m_valid, m_data, m_parity_err);
    end
    idle();
  endtask

  task automatic test_overrun();
    m_ready = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0);
    idle();
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_first: got valid=%b data=%h ovr=%b, want 1 a5 0", m_valid, m_data, overrun);
    end
    send_frame(8'h3C, 1'b0, 1'b0);
    idle();
    n_cmp++;
    if (overrun !== 1'b1 || m_data !== 8'hA5 || m_valid !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_pulse: got ovr=%b data=%h valid=%b, want 1 a5 1", overrun, m_data, m_valid);
    end
    idle();
    n_cmp++;
    if (overrun !== 1'b0 || m_data !== 8'hA5) begin
      n_err++; $display("FAIL ovr_width: got ovr=%b data=%h, want 0 a5", overrun, m_data);
    end
    m_ready = 1'b1;
    idle();
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++; $display("FAIL ovr_drain: got valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_resync();
    logic [7:0] d;
    d = 8'h3C;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat(1'b1, i == 0);
    beat(d[0], 1'b1);
    beat(d[1], 1'b0);
    n_cmp++;
    if (sync_err !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL sync_pulse: got sync=%b busy=%b, want 1 1", sync_err, busy);
    end
    beat(d[2], 1'b0);
    n_cmp++;
    if (sync_err !== 1'b0) begin
      n_err++; $display("FAIL sync_width: got sync=%b want 0", sync_err);
    end
    for (int i = 3; i < 8; i++) beat(d[i], 1'b0);
    beat(1'b0, 1'b0);
    idle();
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 8'h3C || m_parity_err !== 1'b0 || sync_err !== 1'b0) begin
      n_err++;
      $display("FAIL resync_word: got valid=%b data=%h err=%b sync=%b, want 1 3c 0 0",
               m_valid, m_data, m_parity_err, sync_err);
    end
    idle();
  endtask

  task automatic test_gaps();
    m_ready = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b1);
    idle();
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 8'h5A || m_parity_err !== 1'b0) begin
      n_err++;
      $display("FAIL gaps_word: got valid=%b data=%h err=%b, want 1 5a 0", m_valid, m_data, m_parity_err);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    d = 8'h3C;
    m_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b0);
    beat(d[0], 1'b1);
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      n_err++; $display("FAIL b2b_first: got valid=%b data=%h, want 1 a5", m_valid, m_data);
    end
    for (int i = 1; i < 8; i++) beat(d[i], 1'b0);
    beat(1'b1, 1'b0);
    idle();
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 8'h3C || m_parity_err !== 1'b1 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second: got valid=%b data=%h err=%b ovr=%b, want 1 3c 1 0",
               m_valid, m_data, m_parity_err, overrun);
    end
    idle();
  endtask

  task automatic test_accept_and_load();
    logic [7:0] d;
    d = 8'h3C;
    m_ready = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) beat(d[i], i == 0);
    beat(1'b0, 1'b0);
    m_ready = 1'b1;
    idle();
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 8'h3C || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL accept_load: got valid=%b data=%h ovr=%b, want 1 3c 0", m_valid, m_data, overrun);
    end
    idle();
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++; $display("FAIL accept_load_drain: got valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    m_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) beat(1'b1, i == 0);
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0; s_start = 1'b0; s_bit = 1'b0;
    #1;
    n_cmp++;
    if ({m_valid, m_data, m_parity_err, overrun, sync_err, busy} !== 13'h0) begin
      n_err++;
      $display("FAIL midreset_state: got valid=%b data=%h err=%b ovr=%b sync=%b busy=%b, want all 0",
               m_valid, m_data, m_parity_err, overrun, sync_err, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; m_ready = 1'b1;
    idle();
    n_cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL midreset_idle: got valid=%b busy=%b, want 0 0", m_valid, busy);
    end
    send_frame(8'hA5, 1'b0, 1'b0);
    idle();
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || m_parity_err !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_word: got valid=%b data=%h err=%b, want 1 a5 0", m_valid, m_data, m_parity_err);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_overrun();
    test_resync();
    test_gaps();
    test_back_to_back();
    test_accept_and_load();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_serial_parity_deserializer

`default_nettype wire

// File: doc/serial_parity_deserializer.md
# serial_parity_deserializer

- Receive end of the single-bit serial link driven by the mux-based serializer.
- Takes one bit per valid beat, LSB first, forming a WIDTH-bit data word followed by one even-parity bit.
- Checks parity with a running XOR and presents each completed word on a valid/ready output register.
- Reports overrun and resynchronisation events.

## Interface

Parameters:
- WIDTH, 8, data bits per frame; legal range 2..32.

Ports:
- clk, input, 1, single clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- s_bit, input, 1, serial data or parity bit.
- s_valid, input, 1, s_bit is valid this cycle. Gaps are allowed anywhere.
- s_start, input, 1, qualified by s_valid; marks the first data bit of a frame.
- m_data, output, WIDTH, received word; bit 0 is the first bit received.
- m_parity_err, output, 1, parity mismatch for the word in m_data.
- m_valid, output, 1, m_data and m_parity_err are held valid.
- m_ready, input, 1, consumer accepts when m_valid && m_ready.
- overrun, output, 1, one-cycle pulse: a completed frame was dropped.
- sync_err, output, 1, one-cycle pulse: a frame was aborted by s_start.
- busy, output, 1, high while state is not IDLE.

## Operation

- Reset is asynchronous on rst_n low. Reset values:
  - state IDLE, bit counter 0, shift register 0, parity accumulator 0.
  - m_data 0, m_parity_err 0, m_valid 0, overrun 0, sync_err 0.
  - busy is 0, since state is IDLE.
- Reset mid-frame discards the partial frame and any held output word.
- FSM states: IDLE, DATA, PARITY.
  - **IDLE:**
    - s_valid && s_start captures s_bit as bit 0, sets acc = s_bit and count = 1, and goes to DATA.
    - s_valid without s_start is ignored.
  - **DATA:**
    - Each s_valid beat stores s_bit at index count, updates acc ^= s_bit and increments count.
    - After bit WIDTH-1 is stored, go to PARITY.
  - **PARITY:**
    - On s_valid, parity_err = s_bit ^ acc, so the frame is good when the XOR over data and parity is 0.
    - Attempt the output load, then go to IDLE.
- Resync: s_valid && s_start while in DATA or PARITY aborts the current frame.
  - sync_err pulses next cycle.
  - The beat is taken as bit 0 of a new frame, with state DATA and count 1.
  - No output load occurs for the aborted frame.
- Output load:
  - The register is free when m_valid == 0, or when m_valid && m_ready in the same cycle.
  - If free: m_data, m_parity_err and m_valid=1 are loaded.
  - If not free: the frame is dropped, overrun pulses, and the held word is unchanged.
- m_valid clears on m_valid && m_ready when no load occurs in the same cycle.
- m_data and m_parity_err are stable while m_valid && !m_ready.
- s_valid low in any state holds all internal state.
- The bit counter is $clog2(WIDTH+1) bits wide and never exceeds WIDTH.

## Timing

- Latency: m_valid rises on the clock edge that samples the parity beat, so it is visible the cycle after the parity beat.
- Back-to-back input:
  - Full rate is one frame per WIDTH+1 cycles.
  - The first bit of the next frame may arrive the cycle after the parity beat; the FSM is already in IDLE by then.
- Simultaneous accept and load: the new word replaces the old one with no gap, and m_valid stays 1.
- overrun and sync_err: registered, exactly one cycle wide, never both in the same cycle.
- All outputs are registered except busy, which is decoded from state.
- No combinational path from inputs to outputs.

## Structure

- Package serial_link_pkg holds:
  - typedef enum logic [1:0] {IDLE, DATA, PARITY} rx_state_t.
  - A parity-polarity constant, EVEN = 0, shared with the serializer.
- Natural sub-module: out_hold_reg, the WIDTH+1-bit valid/ready holding register.
  - It exposes a load_ok/free signal back to the FSM.
- The FSM, shift register and XOR accumulator stay in the top module.

## Test plan

All scenarios use WIDTH=8.

- **Good frame:** bits 1,0,1,0,0,1,0,1 (0xA5), first bit with s_start, then parity 0, m_ready=1.
  - Required: m_data=0xA5, m_parity_err=0, m_valid for 1 cycle.
- **Bad parity:** same frame with parity bit 1.
  - Required: m_data=0xA5, m_parity_err=1.
- **Overrun:** m_ready=0, send 0xA5 then 0x3C (parity 0 for both).
  - Required: m_data stays 0xA5, overrun pulses once after the second parity beat.
  - Then raise m_ready: m_valid drops after one accept.
- **Resync:** s_start asserted on the 5th bit of a frame, then a full 0x3C frame starting at that beat.
  - Required: sync_err pulses once, then m_data=0x3C with err=0.
- **Gaps:** 0x5A frame with s_valid toggling 1,0,1,0…
  - Required: m_data=0x5A, same result as the gapless case.
- **Reset mid-frame:** rst_n low after 3 bits, then a complete 0xA5 frame.
  - Required: all outputs 0 during reset, then only the 0xA5 word is delivered.
